// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA CPU read path.
package vga_pkg;

  localparam int unsigned NUM_PLANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  typedef enum logic {
    RD_MODE_PLANE = 1'b0,
    RD_MODE_CMP   = 1'b1
  } read_mode_t;

  typedef logic [NUM_PLANES-1:0][15:0] plane_words_t;

  // Byte lane fed to a plane latch: high byte only for an upper-lane access.
  function automatic logic [7:0] lane_byte(input logic [15:0] w, input logic [1:0] sel);
    return (sel == 2'b10) ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/vga_color_cmp.sv
// Colour-compare read: one match bit per pixel across the enabled planes.
// Only built when VGA_READ_MODE1_EN is defined.
`ifdef VGA_READ_MODE1_EN
module vga_color_cmp
  import vga_pkg::*;
(
  input  plane_words_t words,
  input  logic [3:0]   color_compare,
  input  logic [3:0]   color_dont_care,
  output logic [15:0]  match
);

  always_comb begin
    match = '1;
    for (int unsigned b = 0; b < 16; b++) begin
      for (int unsigned p = 0; p < NUM_PLANES; p++) begin
        if (color_dont_care[p] && (words[p][b] != color_compare[p])) begin
          match[b] = 1'b0;
        end
      end
    end
  end

endmodule
`endif

// File: rtl/vga_read_iface.sv
// CPU read port of the VGA plane memory: fetches all four planes per access.
// Colour-compare read mode is enabled by defining VGA_READ_MODE1_EN.
module vga_read_iface
  import vga_pkg::*;
(
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [16:1] wbs_adr_i,
  input  logic [1:0]  wbs_sel_i,
  input  logic        wbs_stb_i,
  output logic [15:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic [17:1] wbm_adr_o,
  output logic        wbm_stb_o,
  input  logic [15:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        memory_mapping1,
  input  logic        read_mode,
  input  logic [1:0]  read_map_select,
  input  logic [3:0]  color_compare,
  input  logic [3:0]  color_dont_care,
  output logic [7:0]  latch0,
  output logic [7:0]  latch1,
  output logic [7:0]  latch2,
  output logic [7:0]  latch3
);

  state_t       state, state_next;
  logic [1:0]   plane, plane_next;
  plane_words_t words, words_next;
  logic         load;
  logic [14:0]  offset;
  logic [15:0]  dat_next;
  logic         unused_adr;

  assign unused_adr = wbs_adr_i[16];
  assign offset     = memory_mapping1 ? {1'b0, wbs_adr_i[14:1]} : wbs_adr_i[15:1];
  assign wbm_adr_o  = {plane, offset};
  assign wbm_stb_o  = (state == ST_READ);
  assign wbs_ack_o  = (state == ST_ACK);

  always_comb begin
    state_next = state;
    plane_next = plane;
    words_next = words;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wbs_stb_i) begin
          state_next = ST_READ;
          plane_next = '0;
        end
      end
      ST_READ: begin
        // An abandoned CPU cycle drops whatever planes were already fetched.
        if (!wbs_stb_i) begin
          state_next = ST_IDLE;
          plane_next = '0;
          words_next = '0;
        end else if (wbm_ack_i) begin
          words_next[plane] = wbm_dat_i;
          plane_next        = plane + 2'd1;
          if (plane == 2'd3) begin
            state_next = ST_ACK;
            load       = 1'b1;
          end
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef VGA_READ_MODE1_EN
  logic [15:0] cmp_match;

  vga_color_cmp u_color_cmp (
    .words           (words_next),
    .color_compare   (color_compare),
    .color_dont_care (color_dont_care),
    .match           (cmp_match)
  );

  assign dat_next = (read_mode_t'(read_mode) == RD_MODE_CMP) ? cmp_match
                                                             : words_next[read_map_select];
`else
  logic unused_mode;

  assign unused_mode = ^{read_mode, color_compare, color_dont_care};
  assign dat_next    = words_next[read_map_select];
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= ST_IDLE;
      plane     <= '0;
      words     <= '0;
      wbs_dat_o <= '0;
      latch0    <= '0;
      latch1    <= '0;
      latch2    <= '0;
      latch3    <= '0;
    end else begin
      state <= state_next;
      plane <= plane_next;
      words <= words_next;
      // Output data and latches see the final plane word on the same edge it arrives.
      if (load) begin
        wbs_dat_o <= dat_next;
        latch0    <= lane_byte(words_next[0], wbs_sel_i);
        latch1    <= lane_byte(words_next[1], wbs_sel_i);
        latch2    <= lane_byte(words_next[2], wbs_sel_i);
        latch3    <= lane_byte(words_next[3], wbs_sel_i);
      end
    end
  end

endmodule

// File: tb/tb_vga_read_iface.sv
// Self-checking bench for vga_read_iface with a zero-wait SRAM model.
module tb_vga_read_iface;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:1] adr;
  logic [1:0]  sel;
  logic        stb;
  logic [15:0] s_dat;
  logic        s_ack;
  logic [17:1] m_adr;
  logic        m_stb;
  logic [15:0] m_dat;
  logic        m_ack;
  logic        map1;
  logic        rmode;
  logic [1:0]  rmap;
  logic [3:0]  ccmp;
  logic [3:0]  cdc;
  logic [7:0]  l0, l1, l2, l3;

  logic [15:0] plane_mem [4];
  logic [14:0] addr_seen [4];

  always #5 clk = ~clk;

  assign m_dat = plane_mem[m_adr[17:16]];
  assign m_ack = m_stb;

  vga_read_iface dut (
    .wb_clk_i        (clk),
    .wb_rst_ni       (rst_n),
    .wbs_adr_i       (adr),
    .wbs_sel_i       (sel),
    .wbs_stb_i       (stb),
    .wbs_dat_o       (s_dat),
    .wbs_ack_o       (s_ack),
    .wbm_adr_o       (m_adr),
    .wbm_stb_o       (m_stb),
    .wbm_dat_i       (m_dat),
    .wbm_ack_i       (m_ack),
    .memory_mapping1 (map1),
    .read_mode       (rmode),
    .read_map_select (rmap),
    .color_compare   (ccmp),
    .color_dont_care (cdc),
    .latch0          (l0),
    .latch1          (l1),
    .latch2          (l2),
    .latch3          (l3)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: edges since the strobe was accepted decide everything.
  bit          busy = 0;
  int          n = 0;
  logic [7:0]  m_lat [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [15:0] m_rd = 16'h0000;
  bit          mon_en = 0;

  function automatic logic [14:0] exp_offset(input logic [15:0] a, input logic m1);
    int w = int'(a);
    return m1 ? 15'(w % 16384) : 15'(w % 32768);
  endfunction

  function automatic logic [15:0] exp_read();
    logic [15:0] r;
    r = plane_mem[rmap];
`ifdef VGA_READ_MODE1_EN
    if (rmode) begin
      for (int b = 0; b < 16; b++) begin
        r[b] = 1'b1;
        for (int p = 0; p < 4; p++)
          if (cdc[p] && plane_mem[p][b] != ccmp[p]) r[b] = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  always @(negedge rst_n) begin
    busy = 0;
    n    = 0;
    for (int p = 0; p < 4; p++) m_lat[p] = 8'h00;
    m_rd = 16'h0000;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (busy) begin
        if (n == 4) busy = 0;
        else if (!stb) busy = 0;
        else begin
          n++;
          if (n == 4) begin
            for (int p = 0; p < 4; p++)
              m_lat[p] = (sel == 2'b10) ? plane_mem[p][15:8] : plane_mem[p][7:0];
            m_rd = exp_read();
          end
        end
      end else if (stb) begin
        busy = 1;
        n    = 0;
      end
    end
    #1;
    if (mon_en && rst_n) begin
      chk("wbm_stb", 32'(m_stb), 32'(busy && n <= 3));
      chk("wbs_ack", 32'(s_ack), 32'(busy && n == 4));
      chk("latches", {l0, l1, l2, l3}, {m_lat[0], m_lat[1], m_lat[2], m_lat[3]});
      chk("wbs_dat", 32'(s_dat), 32'(m_rd));
      if (busy && n <= 3)
        chk("wbm_adr", 32'(m_adr), 32'({n[1:0], exp_offset(adr, map1)}));
    end
  end

  task automatic set_planes(input logic [15:0] a, b, c, d);
    plane_mem[0] = a; plane_mem[1] = b; plane_mem[2] = c; plane_mem[3] = d;
  endtask

  task automatic run_read(output int lat);
    lat = -1;
    @(negedge clk);
    stb = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (m_stb) addr_seen[m_adr[17:16]] = m_adr[15:1];
      if (s_ack) begin
        lat = i;
        break;
      end
    end
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic watch_no_ack(input string name);
    logic seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen |= s_ack;
    end
    chk(name, 32'(seen), 32'(0));
  endtask

  int lat;

  initial begin
    rst_n = 1'b0; adr = 16'h0010; sel = 2'b01; stb = 1'b0; map1 = 1'b0;
    rmode = 1'b0; rmap = 2'd2; ccmp = 4'h0; cdc = 4'h0;
    set_planes(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    for (int p = 0; p < 4; p++) addr_seen[p] = '0;
    #1;
    chk("rst_dat", 32'(s_dat), 32'h0);
    chk("rst_ack", 32'(s_ack), 32'h0);
    chk("rst_stb", 32'(m_stb), 32'h0);
    chk("rst_latches", {l0, l1, l2, l3}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1;

    // Mode 0 plane read, zero-wait SRAM
    run_read(lat);
    chk("latency", 32'(lat), 32'd5);
    chk("mode0_dat", 32'(s_dat), 32'h3333);
    chk("mode0_latches", {l0, l1, l2, l3}, 32'h11223344);

    // Colour compare; map_select 0 makes the plane-read answer identical
    rmode = 1'b1; rmap = 2'd0; ccmp = 4'b0101; cdc = 4'b1111;
    set_planes(16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000);
    run_read(lat);
    chk("cmp_all", 32'(s_dat), 32'hFFFF);
    set_planes(16'h00FF, 16'h0000, 16'hFFFF, 16'h0000);
    run_read(lat);
    chk("cmp_low", 32'(s_dat), 32'h00FF);
`ifdef VGA_READ_MODE1_EN
    cdc = 4'b0000;
    set_planes(16'h1234, 16'h00F0, 16'h5A5A, 16'h0F0F);
    run_read(lat);
    chk("cmp_dontcare0", 32'(s_dat), 32'hFFFF);
    cdc = 4'b0010; ccmp = 4'b0000;
    run_read(lat);
    chk("cmp_plane1_zero", 32'(s_dat), 32'hFF0F);
`else
    cdc = 4'b0000;
    set_planes(16'h1234, 16'h00F0, 16'h5A5A, 16'h0F0F);
    run_read(lat);
    chk("mode_ignored", 32'(s_dat), 32'h1234);
`endif
    rmode = 1'b0;

    // Upper byte lane feeds the latches
    sel = 2'b10; rmap = 2'd3;
    set_planes(16'hAB12, 16'hCD34, 16'hEF56, 16'h0178);
    run_read(lat);
    chk("hi_latches", {l0, l1, l2, l3}, 32'hABCDEF01);
    chk("hi_dat", 32'(s_dat), 32'h0178);

    // CPU abandons the cycle after the second SRAM ack
    sel = 2'b01;
    set_planes(16'h5566, 16'h6677, 16'h7788, 16'h8899);
    @(negedge clk);
    stb = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    stb = 1'b0;
    watch_no_ack("abort_no_ack");
    chk("abort_latches", {l0, l1, l2, l3}, 32'hABCDEF01);
    run_read(lat);
    chk("after_abort_latency", 32'(lat), 32'd5);
    chk("after_abort_latches", {l0, l1, l2, l3}, 32'h66778899);

    // adr carries byte address 0x8002
    adr = 16'h4001; map1 = 1'b1;
    run_read(lat);
    for (int p = 0; p < 4; p++) chk("map1_offset", 32'(addr_seen[p]), 32'h0001);
    map1 = 1'b0;
    run_read(lat);
    chk("map0_offset", 32'(addr_seen[0]), 32'h4001);

    // Reset pulse in the middle of a fetch
    @(negedge clk);
    stb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_plane", 32'(m_adr[17:16]), 32'd2);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    stb   = 1'b0;
    #1;
    chk("mid_rst_stb", 32'(m_stb), 32'h0);
    chk("mid_rst_ack", 32'(s_ack), 32'h0);
    chk("mid_rst_dat", 32'(s_dat), 32'h0);
    chk("mid_rst_latches", {l0, l1, l2, l3}, 32'h0);
    #1;
    rst_n = 1'b1;
    watch_no_ack("reset_no_ack");
    run_read(lat);
    chk("post_reset_latency", 32'(lat), 32'd5);

    repeat (2) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vga_read_iface.md
VGA_READ_IFACE -- requirements
Module: vga_read_iface

Interface
REQ-001 SHALL have port wb_clk_i  in  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port wb_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port wbs_adr_i  in  [16:1]  CPU word address.
REQ-004 SHALL have port wbs_sel_i  in  [1:0]  CPU byte lanes.
REQ-005 SHALL have port wbs_stb_i  in  1  CPU read strobe.
REQ-006 SHALL have port wbs_dat_o  out  [15:0]  read data to CPU.
REQ-007 SHALL have port wbs_ack_o  out  1  read acknowledge to CPU.
REQ-008 SHALL have port wbm_adr_o  out  [17:1]  SRAM address, {plane[1:0], offset[15:1]}.
REQ-009 SHALL have port wbm_stb_o  out  1  SRAM read strobe.
REQ-010 SHALL have port wbm_dat_i  in  [15:0]  SRAM read data.
REQ-011 SHALL have port wbm_ack_i  in  1  SRAM acknowledge.
REQ-012 SHALL have port memory_mapping1  in  1  offset = {1'b0, adr[14:1]} when 1, else adr[15:1].
REQ-013 SHALL have port read_mode  in  1  0 = plane read, 1 = colour compare.
REQ-014 SHALL have port read_map_select  in  [1:0]  plane returned in read mode 0.
REQ-015 SHALL have ports color_compare and color_dont_care  in  [3:0] each  mode-1 compare value and per-plane enable.
REQ-016 SHALL have ports latch0..latch3  out  [7:0] each  plane latches, consumed by the write path.

Function
REQ-017 SHALL implement FSM IDLE, READ, ACK.
- IDLE: wbs_stb_i=1 -> READ, plane=0.
- READ: wbm_stb_o=1. Each wbm_ack_i captures wbm_dat_i into word[plane] and increments plane. Ack at plane 3 -> ACK.
- ACK: wbs_ack_o=1 for exactly one cycle, then IDLE.
REQ-018 SHALL keep wbm_stb_o and wbs_ack_o low outside READ and ACK respectively.
REQ-019 SHALL drive wbm_adr_o = {plane, offset} combinationally from the current plane counter.
REQ-020 SHALL, when wbs_stb_i falls in READ, return to IDLE next cycle without ack, discard captured words and leave latches unchanged.
REQ-021 SHALL update latch0..3 on the ACK-entry edge only, all four together.
- Each latch takes the high byte of word[n] when wbs_sel_i==2'b10, else the low byte.
REQ-022 Read mode 0: wbs_dat_o SHALL be word[read_map_select], registered at ACK entry.
REQ-023 Read mode 1: for each of 16 pixel bits b, wbs_dat_o[b] SHALL be 1 iff, for all planes p with color_dont_care[p]=1, word[p][b]==color_compare[p].
- All-zero color_dont_care SHALL yield 16'hFFFF.
REQ-024 Minimum latency SHALL be 4 SRAM acks + 1 cycle. With zero-wait SRAM: stb at cycle 0, ack at cycle 5.
REQ-025 The CPU master SHALL drop wbs_stb_i in the cycle after wbs_ack_o. A strobe still high in IDLE starts a new read.

Reset
REQ-026 On wb_rst_ni=0, asynchronously: state=IDLE, plane=0, words=0, latches=8'h00, wbs_dat_o=16'h0000, wbs_ack_o=0, wbm_stb_o=0.
REQ-027 Reset asserted mid-read SHALL abort the read with no ack and no latch update.

Configuration
REQ-028 Macro VGA_READ_MODE1_EN:
- Defined: REQ-023 colour compare is implemented.
- Undefined: read_mode is ignored, mode 0 is always used, and the compare logic is absent.

Structure
REQ-029 Shared package vga_pkg SHALL hold the FSM state typedef, the plane-count constant (4) and the read-mode encodings.
REQ-030 Colour-compare logic SHALL be one sub-module, vga_color_cmp (4x16 words plus compare/dont_care in, 16 bits out), instantiated only under VGA_READ_MODE1_EN.

Verification
REQ-031 Mode 0, zero-wait SRAM, planes 1111/2222/3333/4444, map_select=2, sel=01:
- wbs_dat_o=16'h3333, ack at cycle 5.
- latches 11/22/33/44.
REQ-032 Mode 1, compare=4'b0101, dont_care=4'b1111, planes FFFF/0000/FFFF/0000 -> wbs_dat_o=16'hFFFF.
- Same with plane0=00FF -> wbs_dat_o=16'h00FF.
REQ-033 sel=2'b10, planes AB12/CD34/EF56/0178 -> latches AB/CD/EF/01.
REQ-034 wbs_stb_i dropped after the 2nd SRAM ack -> no wbs_ack_o; latches retain prior values; next read starts at plane 0.
REQ-035 memory_mapping1=1, adr=16'h8002 -> wbm_adr_o offsets 15'h0001 for planes 0..3.
REQ-036 wb_rst_ni pulsed low while plane=2 -> all outputs at reset values immediately; no ack afterwards.
